// File: rtl/cider_bus_pkg.sv
// Shared decode constants and the bus-responder state type for the custom-chip window.
package cider_bus_pkg;

  localparam logic [7:0]  CUSTOM_BANK = 8'hDF;
  localparam logic [10:0] INTREQR_OFS = 11'h00F;
  localparam logic [10:0] INTREQ_OFS  = 11'h04E;
  localparam int          INT2_BIT    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_END = 2'd2
  } bus_state_e;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for an asynchronous level input; clears to 0 on reset.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else          r_q <= {r_q[DEPTH-2:0], i_d};
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/intreq_responder.sv
// INT2 pending bit with INTREQR read-back drive on D3 and INTREQ set/clear writes.
module intreq_responder
  import cider_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:1] ADDR,
  input  logic        D15,
  input  logic        D3,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic        ide_int,
  input  logic        int_en,
  output logic        d3_oe,
  output logic        d3_out,
  output logic        pending,
  output logic        irq
);

  bus_state_e r_state, w_state_nxt;
  logic       r_pending, w_pending_nxt;
  logic       r_int_s_d;
  logic       r_drv;
  logic       r_d3_oe, w_d3_oe_nxt;
  logic       r_irq;
  logic       w_int_s, w_int_rise;
  logic       w_custom, w_rd_hit, w_wr_hit, w_capture;
  logic       w_unused_addr;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_n),
    .i_d     (ide_int),
    .o_q     (w_int_s)
  );

  assign w_unused_addr = ^ADDR[15:12];

  assign w_custom   = (ADDR[23:16] == CUSTOM_BANK) && !AS_n;
  assign w_rd_hit   = w_custom && (ADDR[11:1] == INTREQR_OFS) && RW && (!UDS_n || !LDS_n);
  assign w_wr_hit   = w_custom && (ADDR[11:1] == INTREQ_OFS) && !RW && !LDS_n;
  assign w_int_rise = w_int_s && !r_int_s_d;
  assign w_capture  = (r_state == IDLE) && w_rd_hit;

  // Write decisions are assigned after the edge-set so a clear-write beats a simultaneous rise.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    if (w_int_rise) w_pending_nxt = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_rd_hit) begin
          w_state_nxt = DRIVE;
        end else if (w_wr_hit) begin
          w_state_nxt = WAIT_END;
          if (D3) w_pending_nxt = D15;
        end else if (w_custom) begin
          w_state_nxt = WAIT_END;
        end
      end
      DRIVE: begin
        if (AS_n) w_state_nxt = IDLE;
      end
      WAIT_END: begin
        if (AS_n) begin
          w_state_nxt = IDLE;
          if (w_int_s) w_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Drive only while staying in DRIVE, so the enable drops on the edge that sees AS_n high.
  assign w_d3_oe_nxt = (r_state == DRIVE) && (w_state_nxt == DRIVE) && r_drv;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_int_s_d <= 1'b0;
      r_d3_oe   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_int_s_d <= w_int_s;
      r_d3_oe   <= w_d3_oe_nxt;
      r_irq     <= r_pending && int_en;
    end
  end

  // Snapshot of pending for the whole read cycle.
  always_ff @(posedge CLK) begin
    if (w_capture) r_drv <= r_pending;
  end

  assign d3_oe   = r_d3_oe;
  assign d3_out  = 1'b1;
  assign pending = r_pending;
  assign irq     = r_irq;

endmodule

// File: tb/tb_intreq_responder.sv
// Self-checking bench for intreq_responder: directed scenarios plus randomized bus traffic.
module tb_intreq_responder;

  localparam logic [23:0] A_INTREQR = 24'hDFF01E;
  localparam logic [23:0] A_INTREQ  = 24'hDFF09C;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [23:1] ADDR;
  logic        D15, D3, AS_n, UDS_n, LDS_n, RW;
  logic        ide_int, int_en;
  logic        d3_oe, d3_out, pending, irq;

  int errors = 0;
  int checks = 0;

  intreq_responder #(.SYNC_STAGES(2)) dut (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .ADDR    (ADDR),
    .D15     (D15),
    .D3      (D3),
    .AS_n    (AS_n),
    .UDS_n   (UDS_n),
    .LDS_n   (LDS_n),
    .RW      (RW),
    .ide_int (ide_int),
    .int_en  (int_en),
    .d3_oe   (d3_oe),
    .d3_out  (d3_out),
    .pending (pending),
    .irq     (irq)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic bus_idle();
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    ADDR = '0; D15 = 1'b0; D3 = 1'b0;
  endtask

  task automatic bus_start(input logic [23:0] a, input logic rw, input logic [15:0] d,
                           input logic uds, input logic lds);
    ADDR = a[23:1]; RW = rw; D15 = d[15]; D3 = d[3];
    UDS_n = !uds; LDS_n = !lds; AS_n = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] d);
    bus_start(A_INTREQ, 1'b0, d, 1'b1, 1'b1);
    step(1);
    bus_idle();
    step(1);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; bus_idle(); ide_int = 1'b0; int_en = 1'b1;
    step(3);
    checks++; if (d3_oe !== 1'b0)   begin errors++; $display("FAIL reset_d3_oe: got %b want 0", d3_oe); end
    checks++; if (d3_out !== 1'b1)  begin errors++; $display("FAIL reset_d3_out: got %b want 1", d3_out); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    checks++; if (irq !== 1'b0)     begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    RESET_n = 1'b1;
    step(2);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL post_reset_pending: got %b want 0", pending); end
  endtask

  task automatic test_int_path(input logic en);
    int_en = en;
    ide_int = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      checks++;
      if (pending !== (e == 3)) begin errors++; $display("FAIL int_latency_e%0d: pending got %b want %b", e, pending, (e == 3)); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq); end
    step(1);
    checks++; if (irq !== en) begin errors++; $display("FAIL irq_follow en=%b: got %b want %b", en, irq, en); end
    step(2);
    checks++; if (irq !== en) begin errors++; $display("FAIL irq_hold en=%b: got %b want %b", en, irq, en); end
    ide_int = 1'b0; step(3);
    do_write(16'h0008);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL int_cleanup: pending got %b want 0", pending); end
  endtask

  task automatic test_read_pending();
    do_write(16'h8008);
    bus_start(A_INTREQR, 1'b1, 16'h0000, 1'b0, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      step(1);
      checks++;
      if (d3_oe !== (e >= 2)) begin errors++; $display("FAIL read_drive_e%0d: d3_oe got %b want %b", e, d3_oe, (e >= 2)); end
    end
    bus_idle();
    step(1);
    checks++; if (d3_oe !== 1'b0) begin errors++; $display("FAIL read_release: d3_oe got %b want 0", d3_oe); end
  endtask

  task automatic test_read_not_pending();
    do_write(16'h0008);
    ide_int = 1'b1;
    bus_start(A_INTREQR, 1'b1, 16'h0000, 1'b1, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if (d3_oe !== 1'b0) begin errors++; $display("FAIL nopend_read_e%0d: d3_oe got %b want 0", e, d3_oe); end
    end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_in_drive: pending got %b want 1", pending); end
    bus_idle(); step(1);
    checks++; if (d3_oe !== 1'b0) begin errors++; $display("FAIL nopend_release: d3_oe got %b want 0", d3_oe); end
    ide_int = 1'b0; step(3);
    do_write(16'h0008);
  endtask

  task automatic test_clear_rearm();
    ide_int = 1'b1; step(4);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rearm_pre: pending got %b want 1", pending); end
    bus_start(A_INTREQ, 1'b0, 16'h0008, 1'b1, 1'b1);
    step(1);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL clear_hit: pending got %b want 0", pending); end
    step(1);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL clear_wait: pending got %b want 0", pending); end
    bus_idle(); step(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rearm_exit: pending got %b want 1", pending); end
    ide_int = 1'b0; step(3);
    do_write(16'h0008);
  endtask

  task automatic test_simultaneous();
    do_write(16'h8008);
    ide_int = 1'b1; step(2);
    bus_start(A_INTREQ, 1'b0, 16'h0008, 1'b1, 1'b1);
    step(1);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL clear_vs_rise: pending got %b want 0", pending); end
    bus_idle(); step(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL clear_vs_rise_rearm: pending got %b want 1", pending); end
    ide_int = 1'b0; step(3);
    do_write(16'h0008);
    ide_int = 1'b1; step(2);
    bus_start(A_INTREQ, 1'b0, 16'h8008, 1'b1, 1'b1);
    step(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL set_vs_rise: pending got %b want 1", pending); end
    bus_idle(); step(1);
    ide_int = 1'b0; step(3);
    do_write(16'h0008);
  endtask

  task automatic test_set_nochange();
    bus_start(A_INTREQ, 1'b0, 16'h8008, 1'b1, 1'b1); step(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL set_write: pending got %b want 1", pending); end
    bus_idle(); step(1);
    do_write(16'h8004);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL d3_zero_write: pending got %b want 1", pending); end
    do_write(16'h0008);
    bus_start(A_INTREQ, 1'b0, 16'h8008, 1'b1, 1'b0); step(1);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL uds_only_write: pending got %b want 0", pending); end
    bus_idle(); step(1);
  endtask

  task automatic test_back_to_back();
    bus_start(A_INTREQR, 1'b1, 16'h0000, 1'b1, 1'b1); step(2);
    bus_start(A_INTREQ, 1'b0, 16'h8008, 1'b1, 1'b1); step(2);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_read_then_write: pending got %b want 0", pending); end
    bus_idle(); step(1);
    bus_start(A_INTREQ, 1'b0, 16'h8008, 1'b1, 1'b1); step(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_after_idle: pending got %b want 1", pending); end
    bus_start(A_INTREQ, 1'b0, 16'h0008, 1'b1, 1'b1); step(2);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_write_then_write: pending got %b want 1", pending); end
    bus_idle(); step(1);
    do_write(16'h0008);
  endtask

  task automatic test_reset_mid_drive();
    do_write(16'h8008);
    bus_start(A_INTREQR, 1'b1, 16'h0000, 1'b0, 1'b1); step(2);
    checks++; if (d3_oe !== 1'b1) begin errors++; $display("FAIL mid_drive_pre: d3_oe got %b want 1", d3_oe); end
    #2 RESET_n = 1'b0;
    #1;
    checks++; if (d3_oe !== 1'b0)   begin errors++; $display("FAIL async_reset_d3_oe: got %b want 0", d3_oe); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL async_reset_pending: got %b want 0", pending); end
    bus_idle(); step(2);
    #2 RESET_n = 1'b1;
    step(1);
    bus_start(A_INTREQR, 1'b1, 16'h0000, 1'b0, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      step(1);
      checks++;
      if (d3_oe !== 1'b0) begin errors++; $display("FAIL post_reset_read_e%0d: d3_oe got %b want 0", e, d3_oe); end
    end
    bus_idle(); step(1);
  endtask

  task automatic test_random();
    logic        m_pend;
    logic        en;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [10:0] ofs;
    logic [7:0]  bank;
    logic [23:0] a;
    int          kind, len;
    m_pend = 1'b0;
    ide_int = 1'b0;
    for (int t = 0; t < 40; t++) begin
      en = 1'($urandom);
      int_en = en;
      kind = $urandom_range(0, 4);
      len = $urandom_range(1, 4);
      d = 16'($urandom);
      case (kind)
        0: begin
          ds = 2'($urandom_range(1, 3));
          bus_start(A_INTREQR, 1'b1, d, ds[1], ds[0]);
        end
        1: begin
          bus_start(A_INTREQ, 1'b0, d, 1'($urandom), 1'b1);
          if (d[3]) m_pend = d[15];
        end
        2: bus_start(A_INTREQ, 1'b0, d, 1'b1, 1'b0);
        3: begin
          do ofs = 11'($urandom); while (ofs == 11'h00F || ofs == 11'h04E);
          a = {8'hDF, 4'hF, ofs, 1'b0};
          bus_start(a, 1'($urandom), d, 1'b1, 1'b1);
        end
        default: begin
          bank = 8'($urandom);
          if (bank == 8'hDF) bank = 8'hBF;
          a = {bank, 4'hF, 11'h04E, 1'b0};
          bus_start(a, 1'b0, d | 16'h0008, 1'b1, 1'b1);
        end
      endcase
      for (int e = 1; e <= len; e++) begin
        step(1);
        checks++;
        if (d3_oe !== (kind == 0 && e >= 2 && m_pend)) begin
          errors++;
          $display("FAIL rand_t%0d_k%0d_e%0d: d3_oe got %b want %b", t, kind, e, d3_oe, (kind == 0 && e >= 2 && m_pend));
        end
      end
      bus_idle(); step(1);
      checks++;
      if (d3_oe !== 1'b0) begin errors++; $display("FAIL rand_t%0d_release: d3_oe got %b want 0", t, d3_oe); end
      checks++;
      if (pending !== m_pend) begin errors++; $display("FAIL rand_t%0d_k%0d_pending: got %b want %b", t, kind, pending, m_pend); end
      checks++;
      if (irq !== (m_pend && en)) begin errors++; $display("FAIL rand_t%0d_irq: got %b want %b", t, irq, (m_pend && en)); end
    end
  endtask

  initial begin
    RESET_n = 1'b0;
    bus_idle();
    ide_int = 1'b0;
    int_en = 1'b0;
    test_reset();
    test_int_path(1'b1);
    test_int_path(1'b0);
    test_read_pending();
    test_read_not_pending();
    test_clear_rearm();
    test_simultaneous();
    test_set_nochange();
    test_back_to_back();
    test_reset_mid_drive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intreq_responder.md
# intreq_responder

Bus-side responder for the IDE interrupt on the Zorro/68000 custom-chip window. Holds the board's INT2 pending bit, drives D3 high during CPU reads of INTREQR ($DFF01E) so the OS sees the PORTS request, and applies set/clear writes to INTREQ ($DFF09C). It sits beside the INTENA shadow logic, which supplies the enable qualifier, and feeds the IPL encoder through `irq`.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `ide_int`; minimum 2.

Ports:
- `CLK`  in  1  board clock; bus strobes are sampled on its rising edge.
- `RESET_n`  in  1  asynchronous, active-low reset.
- `ADDR`  in  23 (`[23:1]`)  CPU address bus.
- `D15`  in  1  data bit 15 (SET/CLR).
- `D3`  in  1  data bit 3 (INT2/PORTS).
- `AS_n`, `UDS_n`, `LDS_n`  in  1 each  68000 strobes.
- `RW`  in  1  1 = read.
- `ide_int`  in  1  asynchronous level interrupt from the IDE drive.
- `int_en`  in  1  INT2 enable AND master enable, from the INTENA shadow.
- `d3_oe`  out  1  enable for the D3 bus driver.
- `d3_out`  out  1  value driven on D3; constant 1.
- `pending`  out  1  INT2 pending bit.
- `irq`  out  1  `pending && int_en`, registered.

## Operation

- `ide_int` passes through a `SYNC_STAGES`-flop synchronizer to give `int_s`. The rising edge of `int_s` sets `pending`.
- A cycle is decoded when `ADDR[23:16]==8'hDF` and `AS_n`==0.
  - `rd_hit`: `ADDR[11:1]==11'b00000001111`, `RW`=1, and `UDS_n`=0 or `LDS_n`=0.
  - `wr_hit`: `ADDR[11:1]==11'b00001001110`, `RW`=0, `LDS_n`=0.
  - A write with only `UDS_n` asserted goes to WAIT_END without any change.
- FSM states: IDLE, DRIVE, WAIT_END.
  - IDLE → DRIVE on `rd_hit`. On that edge, `drv` is captured from `pending` and frozen for the whole bus cycle.
  - IDLE → WAIT_END on `wr_hit`. The write is applied exactly once, on that edge:
    - `D3`=1 and `D15`=1: set `pending`.
    - `D3`=1 and `D15`=0: clear `pending`.
    - `D3`=0: no change.
  - IDLE → WAIT_END on any other custom-window access with `AS_n`=0.
  - DRIVE → IDLE when `AS_n`=1.
  - WAIT_END → IDLE when `AS_n`=1. On that edge, if `int_s`=1 then `pending` re-sets (level re-arm).
- `d3_oe` = (state==DRIVE) && `drv`, registered. When not pending, the block never drives D3, so Paula's value stands.
- `irq` is updated every cycle from `pending && int_en`.
- Simultaneous events:
  - `int_s` rising edge in the same cycle as a clear-write: the clear wins; re-arm occurs at WAIT_END exit.
  - `int_s` rising edge in the same cycle as a set-write: `pending`=1.
  - `pending` changing while in DRIVE does not alter `d3_oe`.

## Timing

- Reset values: `d3_oe`=0, `d3_out`=1, `pending`=0, `irq`=0, state=IDLE, synchronizer cleared.
- Reset asserted mid-cycle drops `d3_oe` immediately (asynchronous).
- `d3_oe` rises 1 CLK after the first edge at which `rd_hit` is sampled.
- `d3_oe` falls on the first edge at which `AS_n`=1 is sampled, at most 1 CLK after `AS_n` rises.
- `ide_int` to `pending`: `SYNC_STAGES`+1 edges (3 at default).
- `pending` to `irq`: 1 edge.
- Clear-write to `pending`=0: same edge as the IDLE→WAIT_END transition.
- Back-to-back cycles: IDLE must be re-entered, which requires `AS_n` high for at least one sampled edge, before a new hit is accepted.

## Structure

- Shared package `cider_bus_pkg`: `CUSTOM_BANK`=8'hDF, `INTREQR_OFS`=11'h00F, `INTREQ_OFS`=11'h04E, `INT2_BIT`=3, and the state enum {IDLE, DRIVE, WAIT_END}.
- Sub-module `sync_ff` (parameterised depth, async-reset-to-0 flop chain), instantiated for `ide_int`.
- Everything else lives in one always block plus the output registers.

## Test plan

- Reset → all outputs at reset values.
  - Raise `ide_int` → `pending`=1 after 3 edges; `irq`=1 on the next edge if `int_en`=1.
  - With `int_en`=0, `irq` stays 0.
- `pending`=1, read $DFF01E (`RW`=1, `LDS_n`=0) for 4 CLK:
  - `d3_oe`=1 from the 2nd edge.
  - `d3_oe`=0 one edge after `AS_n` rises.
- `pending`=0, same read → `d3_oe` stays 0 throughout.
- Write $DFF09C data 16'h0008 with `ide_int` low → `pending`=0 on the hit edge.
  - Repeat with `ide_int` still high → `pending` re-sets on the edge where `AS_n`=1 is sampled.
- Write $DFF09C data 16'h8008 with `ide_int`=0 → `pending`=1.
  - Write 16'h8004 → no change.
  - UDS-only write → no change.
- Assert `RESET_n`=0 mid-DRIVE → `d3_oe` goes 0 without a clock edge.
  - After release, a read of $DFF01E with `pending`=0 does not drive.
